// File: rtl/tile_pixel_generator.sv
// Tile-map pixel generator: tile number, colour attribute, font row and palette fetch per strobed pixel.
// Optional TILE_FETCH_CACHE_EN reuses the previous tile/attribute/font fetch when the addresses repeat.
module tile_pixel_generator #(
    parameter int TILE_COLS_LOG2 = 6,
    parameter int TILE_ROWS_LOG2 = 5,
    parameter int SCALE_LOG2     = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pixel_strobe,
    input  logic                                   vga_blank,
    input  logic [9:0]                             cycle,
    input  logic [8:0]                             scanline,
    input  logic [8:0]                             scroll_x,
    input  logic [7:0]                             scroll_y,
    output logic [TILE_COLS_LOG2+TILE_ROWS_LOG2-1:0] tile_memory_read_addr,
    output logic                                   tile_memory_read_enable,
    input  logic [7:0]                             tile_memory_read_data,
    output logic [11:0]                            attribute_memory_read_addr,
    output logic                                   attribute_memory_read_enable,
    input  logic [7:0]                             attribute_memory_read_data,
    output logic [3:0]                             color_memory_read_addr,
    output logic                                   color_memory_read_enable,
    input  logic [7:0]                             color_memory_read_data,
    output logic [7:0]                             pixel_data,
    output logic                                   pixel_valid,
    output logic                                   overrun
);

    localparam int TA = TILE_COLS_LOG2 + TILE_ROWS_LOG2;
    localparam int XW = TILE_COLS_LOG2 + 3;
    localparam int YW = TILE_ROWS_LOG2 + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP,
        S_FONT,
        S_COLOR,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_accept;
    logic w_missed;
    logic w_map_done;
    logic w_font_done;
    logic w_color_done;

    logic [8:0]    r_scroll_x_eff;
    logic [7:0]    r_scroll_y_eff;
    logic          r_blank;
    logic [2:0]    r_rcol;
    logic [2:0]    r_rrow;
    logic [7:0]    r_tile_num;
    logic [7:0]    r_attr;
    logic [7:0]    r_font;
    logic          r_map_hit;
    logic          r_font_hit;

    logic          w_frame_start;
    logic [8:0]    w_sx;
    logic [7:0]    w_sy;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [TA-1:0] w_tile_addr;
    logic [7:0]    w_tile_num;
    logic [7:0]    w_attr_cur;
    logic [11:0]   w_font_addr;
    logic [7:0]    w_font_cur;
    logic [3:0]    w_color_addr;
    logic          w_map_hit_next;
    logic          w_font_hit_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (pixel_strobe) w_state_next = S_MAP;
            S_MAP:   w_state_next = S_FONT;
            S_FONT:  w_state_next = S_COLOR;
            S_COLOR: w_state_next = S_OUT;
            S_OUT:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept     = (r_state == S_IDLE) && pixel_strobe;
        w_missed     = (r_state != S_IDLE) && pixel_strobe;
        w_map_done   = (r_state == S_MAP);
        w_font_done  = (r_state == S_FONT);
        w_color_done = (r_state == S_COLOR);
    end

    // The frame-start pixel already uses the freshly presented scroll values.
    always_comb begin
        w_frame_start = (cycle == '0) && (scanline == '0);
        w_sx          = w_frame_start ? scroll_x : r_scroll_x_eff;
        w_sy          = w_frame_start ? scroll_y : r_scroll_y_eff;
        w_x           = XW'(cycle >> SCALE_LOG2) + XW'(w_sx);
        w_y           = YW'(scanline >> SCALE_LOG2) + YW'(w_sy);
        w_tile_addr   = {w_y[YW-1:3], w_x[XW-1:3]};
    end

    always_comb begin
        w_tile_num   = r_map_hit ? r_tile_num : tile_memory_read_data;
        w_attr_cur   = r_map_hit ? r_attr : attribute_memory_read_data;
        w_font_addr  = {1'b1, w_tile_num, r_rrow};
        w_font_cur   = r_font_hit ? r_font : attribute_memory_read_data;
        w_color_addr = w_font_cur[r_rcol] ? r_attr[7:4] : r_attr[3:0];
    end

`ifdef TILE_FETCH_CACHE_EN
    logic          r_cache_valid;
    logic [TA-1:0] r_last_tile_addr;
    logic [11:0]   r_last_font_addr;

    always_comb begin
        w_map_hit_next  = r_cache_valid && (w_tile_addr == r_last_tile_addr);
        w_font_hit_next = r_map_hit && (w_font_addr == r_last_font_addr);
    end

    // Cache becomes valid only once a non-blank fetch has fully completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cache_valid    <= 1'b0;
            r_last_tile_addr <= '0;
            r_last_font_addr <= '0;
        end else begin
            if (w_accept) begin
                if (vga_blank) begin
                    r_cache_valid <= 1'b0;
                end else begin
                    r_last_tile_addr <= w_tile_addr;
                end
            end
            if (w_map_done && !r_blank) begin
                r_last_font_addr <= w_font_addr;
            end
            if (w_color_done && !r_blank) begin
                r_cache_valid <= 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_map_hit_next  = 1'b0;
        w_font_hit_next = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scroll_x_eff               <= '0;
            r_scroll_y_eff               <= '0;
            r_blank                      <= 1'b0;
            r_rcol                       <= '0;
            r_rrow                       <= '0;
            r_tile_num                   <= '0;
            r_attr                       <= '0;
            r_font                       <= '0;
            r_map_hit                    <= 1'b0;
            r_font_hit                   <= 1'b0;
            tile_memory_read_addr        <= '0;
            tile_memory_read_enable      <= 1'b0;
            attribute_memory_read_addr   <= '0;
            attribute_memory_read_enable <= 1'b0;
            color_memory_read_addr       <= '0;
            color_memory_read_enable     <= 1'b0;
            pixel_data                   <= '0;
            pixel_valid                  <= 1'b0;
            overrun                      <= 1'b0;
        end else begin
            tile_memory_read_enable      <= 1'b0;
            attribute_memory_read_enable <= 1'b0;
            color_memory_read_enable     <= 1'b0;
            pixel_valid                  <= 1'b0;

            if (w_missed) begin
                overrun <= 1'b1;
            end

            if (w_accept) begin
                r_blank    <= vga_blank;
                r_rcol     <= w_x[2:0];
                r_rrow     <= w_y[2:0];
                r_map_hit  <= !vga_blank && w_map_hit_next;
                r_font_hit <= 1'b0;
                if (w_frame_start) begin
                    r_scroll_x_eff <= scroll_x;
                    r_scroll_y_eff <= scroll_y;
                end
                if (!vga_blank && !w_map_hit_next) begin
                    tile_memory_read_addr        <= w_tile_addr;
                    tile_memory_read_enable      <= 1'b1;
                    attribute_memory_read_addr   <= {1'b0, 11'(w_tile_addr)};
                    attribute_memory_read_enable <= 1'b1;
                end
            end

            if (w_map_done && !r_blank) begin
                r_tile_num <= w_tile_num;
                r_attr     <= w_attr_cur;
                r_font_hit <= w_font_hit_next;
                if (!w_font_hit_next) begin
                    attribute_memory_read_addr   <= w_font_addr;
                    attribute_memory_read_enable <= 1'b1;
                end
            end

            if (w_font_done && !r_blank) begin
                r_font                   <= w_font_cur;
                color_memory_read_addr   <= w_color_addr;
                color_memory_read_enable <= 1'b1;
            end

            if (w_color_done) begin
                pixel_data  <= r_blank ? '0 : color_memory_read_data;
                pixel_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tile_pixel_generator.sv
// Directed bench for tile_pixel_generator: vector table plus overrun, reset and fetch-count sequences.
module tb_tile_pixel_generator;

    logic        clk;
    logic        rst;
    logic        pixel_strobe;
    logic        vga_blank;
    logic [9:0]  cycle;
    logic [8:0]  scanline;
    logic [8:0]  scroll_x;
    logic [7:0]  scroll_y;
    logic [10:0] tile_memory_read_addr;
    logic        tile_memory_read_enable;
    logic [7:0]  tile_memory_read_data;
    logic [11:0] attribute_memory_read_addr;
    logic        attribute_memory_read_enable;
    logic [7:0]  attribute_memory_read_data;
    logic [3:0]  color_memory_read_addr;
    logic        color_memory_read_enable;
    logic [7:0]  color_memory_read_data;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        overrun;

    tile_pixel_generator #(
        .TILE_COLS_LOG2(6),
        .TILE_ROWS_LOG2(5),
        .SCALE_LOG2    (1)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .pixel_strobe                (pixel_strobe),
        .vga_blank                   (vga_blank),
        .cycle                       (cycle),
        .scanline                    (scanline),
        .scroll_x                    (scroll_x),
        .scroll_y                    (scroll_y),
        .tile_memory_read_addr       (tile_memory_read_addr),
        .tile_memory_read_enable     (tile_memory_read_enable),
        .tile_memory_read_data       (tile_memory_read_data),
        .attribute_memory_read_addr  (attribute_memory_read_addr),
        .attribute_memory_read_enable(attribute_memory_read_enable),
        .attribute_memory_read_data  (attribute_memory_read_data),
        .color_memory_read_addr      (color_memory_read_addr),
        .color_memory_read_enable    (color_memory_read_enable),
        .color_memory_read_data      (color_memory_read_data),
        .pixel_data                  (pixel_data),
        .pixel_valid                 (pixel_valid),
        .overrun                     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] tile_mem [2048];
    logic [7:0] attr_mem [4096];
    logic [7:0] pal_mem  [16];

    // Registered-address memories: data appears half a clock after the enabled address.
    always @(negedge clk) begin
        if (tile_memory_read_enable)      tile_memory_read_data      <= tile_mem[tile_memory_read_addr];
        if (attribute_memory_read_enable) attribute_memory_read_data <= attr_mem[attribute_memory_read_addr];
        if (color_memory_read_enable)     color_memory_read_data     <= pal_mem[color_memory_read_addr];
    end

    int cnt_tile, cnt_attr, cnt_color;
    initial begin
        cnt_tile = 0; cnt_attr = 0; cnt_color = 0;
        forever begin
            @(posedge clk);
            if (tile_memory_read_enable)      cnt_tile++;
            if (attribute_memory_read_enable) cnt_attr++;
            if (color_memory_read_enable)     cnt_color++;
        end
    end

    typedef struct packed {
        logic        blank;
        logic [9:0]  cyc;
        logic [8:0]  line;
        logic [8:0]  sx;
        logic [7:0]  sy;
        logic [10:0] tile_a;
        logic [11:0] font_a;
        logic [3:0]  col_a;
        logic [7:0]  pix;
    } vec_t;

    typedef struct packed {
        logic [10:0] tile_a;
        logic [11:0] attr_map_a;
        logic [11:0] font_a;
        logic [3:0]  color_a;
        logic [7:0]  pix;
        logic [2:0]  vshape;
        logic [15:0] dt;
        logic [15:0] da;
        logic [15:0] dc;
    } res_t;

    int n_vec;
    int n_miss;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {24'd0, pixel_data, pixel_valid, overrun,
                tile_memory_read_addr, tile_memory_read_enable,
                attribute_memory_read_addr, attribute_memory_read_enable,
                color_memory_read_addr, color_memory_read_enable};
    endfunction

    task automatic do_strobe(input vec_t v, output res_t r);
        int t0, a0, c0;
        t0 = cnt_tile; a0 = cnt_attr; c0 = cnt_color;
        vga_blank = v.blank; cycle = v.cyc; scanline = v.line;
        scroll_x = v.sx; scroll_y = v.sy; pixel_strobe = 1'b1;
        @(posedge clk); #1;
        pixel_strobe = 1'b0;
        r.tile_a     = tile_memory_read_addr;
        r.attr_map_a = attribute_memory_read_addr;
        @(posedge clk); #1;
        r.font_a = attribute_memory_read_addr;
        @(posedge clk); #1;
        r.color_a   = color_memory_read_addr;
        r.vshape[2] = pixel_valid;
        @(posedge clk); #1;
        r.pix       = pixel_data;
        r.vshape[1] = pixel_valid;
        @(posedge clk); #1;
        r.vshape[0] = pixel_valid;
        r.dt = 16'(cnt_tile - t0);
        r.da = 16'(cnt_attr - a0);
        r.dc = 16'(cnt_color - c0);
    endtask

    vec_t vecs [8];
    vec_t v;
    res_t r;
    int   nv;
    int   t0, a0, c0;

    initial begin
        n_vec = 0; n_miss = 0;
        rst = 1'b1; pixel_strobe = 1'b0; vga_blank = 1'b0;
        cycle = '0; scanline = '0; scroll_x = '0; scroll_y = '0;

        for (int i = 0; i < 2048; i++) tile_mem[i] = 8'h00;
        for (int i = 0; i < 4096; i++) attr_mem[i] = 8'h00;
        for (int i = 0; i < 16; i++)   pal_mem[i]  = 8'h00;
        tile_mem[11'h001] = 8'h41;  attr_mem[12'h001] = 8'h2C;  attr_mem[12'hA0A] = 8'h02;
        tile_mem[11'h042] = 8'h07;  attr_mem[12'h042] = 8'h9E;  attr_mem[12'h83A] = 8'h10;
        tile_mem[11'h7FF] = 8'hFF;  attr_mem[12'h7FF] = 8'h5A;  attr_mem[12'hFFF] = 8'h80;
        pal_mem[2] = 8'h5A; pal_mem[4'hC] = 8'h33; pal_mem[9] = 8'hC4;
        pal_mem[4'hE] = 8'h77; pal_mem[5] = 8'h21;

        //            blank cyc     line    sx      sy    tile     font      col   pix
        vecs[0] = '{1'b0, 10'd18,   9'd4,   9'd0,   8'd0, 11'h001, 12'hA0A, 4'h2, 8'h5A};
        vecs[1] = '{1'b0, 10'd40,   9'd20,  9'd0,   8'd0, 11'h042, 12'h83A, 4'h9, 8'hC4};
        vecs[2] = '{1'b0, 10'd16,   9'd4,   9'd0,   8'd0, 11'h001, 12'hA0A, 4'hC, 8'h33};
        vecs[3] = '{1'b0, 10'd42,   9'd20,  9'd0,   8'd0, 11'h042, 12'h83A, 4'hE, 8'h77};
        vecs[4] = '{1'b0, 10'd1022, 9'd510, 9'd0,   8'd0, 11'h7FF, 12'hFFF, 4'h5, 8'h21};
        vecs[5] = '{1'b0, 10'd18,   9'd6,   9'd0,   8'd0, 11'h001, 12'hA0B, 4'hC, 8'h33};
        vecs[6] = '{1'b1, 10'd18,   9'd4,   9'd0,   8'd0, 11'h000, 12'h000, 4'h0, 8'h00};
        vecs[7] = '{1'b0, 10'd18,   9'd4,   9'd100, 8'd0, 11'h001, 12'hA0A, 4'h2, 8'h5A};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_strobe(vecs[i], r);
            chk($sformatf("vec%0d pixel", i), r.pix, vecs[i].pix);
            chk($sformatf("vec%0d valid_shape", i), r.vshape, 3'b010);
            if (vecs[i].blank) begin
                chk($sformatf("vec%0d reads", i), {r.dt, r.da, r.dc}, 48'd0);
            end else begin
                chk($sformatf("vec%0d tile_addr", i), r.tile_a, vecs[i].tile_a);
                chk($sformatf("vec%0d attr_map_addr", i), r.attr_map_a, {1'b0, vecs[i].tile_a});
                chk($sformatf("vec%0d font_addr", i), r.font_a, vecs[i].font_a);
                chk($sformatf("vec%0d color_addr", i), r.color_a, vecs[i].col_a);
                chk($sformatf("vec%0d reads", i), {r.dt, r.da, r.dc}, {16'd1, 16'd2, 16'd1});
            end
        end

        // Frame-start scroll latch with wrap, then mid-frame scroll change ignored.
        v = '{1'b0, 10'd0, 9'd0, 9'd511, 8'd255, 11'h0, 12'h0, 4'h0, 8'h0};
        do_strobe(v, r);
        chk("fs_wrap tile_addr", r.tile_a, 11'h7FF);
        chk("fs_wrap pixel", r.pix, 8'h21);
        v = '{1'b0, 10'd18, 9'd4, 9'd100, 8'd3, 11'h0, 12'h0, 4'h0, 8'h0};
        do_strobe(v, r);
        chk("midframe tile_addr", r.tile_a, 11'h001);
        chk("midframe font_addr", r.font_a, 12'hA09);
        chk("midframe pixel", r.pix, 8'h33);
        v = '{1'b0, 10'd0, 9'd0, 9'd100, 8'd3, 11'h0, 12'h0, 4'h0, 8'h0};
        do_strobe(v, r);
        chk("next_frame tile_addr", r.tile_a, 11'h00C);
        v = '{1'b0, 10'd0, 9'd0, 9'd0, 8'd0, 11'h0, 12'h0, 4'h0, 8'h0};
        do_strobe(v, r);
        chk("scroll_restore tile_addr", r.tile_a, 11'h000);

        // Second strobe two clocks after the first.
        chk("overrun_initial", overrun, 1'b0);
        vga_blank = 1'b0; cycle = 10'd18; scanline = 9'd4; scroll_x = '0; scroll_y = '0;
        pixel_strobe = 1'b1;
        @(posedge clk); #1 pixel_strobe = 1'b0;
        @(posedge clk); #1 pixel_strobe = 1'b1;
        @(posedge clk); #1 pixel_strobe = 1'b0;
        nv = 0;
        repeat (8) begin
            if (pixel_valid) nv++;
            @(posedge clk); #1;
        end
        chk("overrun_set", overrun, 1'b1);
        chk("overrun_pixel_count", nv, 1);
        do_strobe(vecs[0], r);
        chk("after_overrun pixel", r.pix, 8'h5A);
        chk("overrun_sticky", overrun, 1'b1);

        // Reset asserted while the FONT read is in flight.
        vga_blank = 1'b0; cycle = 10'd18; scanline = 9'd4; pixel_strobe = 1'b1;
        @(posedge clk); #1 pixel_strobe = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("rst_in_font outputs", all_outs(), 64'd0);
        @(posedge clk); #1;
        chk("rst_hold outputs", all_outs(), 64'd0);
        rst = 1'b0;
        do_strobe(vecs[0], r);
        chk("post_reset tile_addr", r.tile_a, 11'h001);
        chk("post_reset pixel", r.pix, 8'h5A);
        chk("post_reset valid_shape", r.vshape, 3'b010);

        // Eight pixels across one tile row of font bits.
        v = '{1'b1, 10'd100, 9'd100, 9'd0, 8'd0, 11'h0, 12'h0, 4'h0, 8'h0};
        do_strobe(v, r);
        t0 = cnt_tile; a0 = cnt_attr; c0 = cnt_color;
        for (int k = 0; k < 8; k++) begin
            v = '{1'b0, 10'(16 + 2 * k), 9'd4, 9'd0, 8'd0, 11'h0, 12'h0, 4'h0, 8'h0};
            do_strobe(v, r);
            chk($sformatf("row_px%0d pixel", k), r.pix, (k == 1) ? 8'h5A : 8'h33);
        end
        chk("row color_reads", cnt_color - c0, 8);
`ifdef TILE_FETCH_CACHE_EN
        chk("row tile_reads", cnt_tile - t0, 1);
        chk("row attr_reads", cnt_attr - a0, 2);
`else
        chk("row tile_reads", cnt_tile - t0, 8);
        chk("row attr_reads", cnt_attr - a0, 16);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
